// File: rtl/pipeline_hazard_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, mul/div occupancy, HALT.
// Optional HAZARD_R0_FILTER_EN: a load targeting R0 never raises a load-use stall.
module pipeline_hazard_unit #(
  parameter int REG_ADDR_W    = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_muldiv_start,
  input  logic                  branch_taken,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_stop,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_write_en,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic                  muldiv_busy,
  output logic                  halted
);

  // Counter holds the remaining MULDIV cycles after the current one; the start cycle is spent in RUN.
  localparam int CNT_W = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_MULDIV = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs1_match, rs2_match, rd_valid, load_use_hit;

  assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);

`ifdef HAZARD_R0_FILTER_EN
  assign rd_valid = (ex_rd != '0);
`else
  assign rd_valid = 1'b1;
`endif

  assign load_use_hit = ex_mem_read && rd_valid && (rs1_match || rs2_match);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_stop        = 1'b0;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_write_en = 1'b1;
    id_ex_bubble   = 1'b0;
    ex_mem_bubble  = 1'b0;
    muldiv_busy    = 1'b0;
    halted         = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_muldiv_start) begin
          pc_stop        = 1'b1;
          if_id_write_en = 1'b0;
          id_ex_write_en = 1'b0;
          ex_mem_bubble  = 1'b1;
          muldiv_busy    = 1'b1;
          state_d        = ST_MULDIV;
          cnt_d          = CNT_LOAD;
        end else if (branch_taken) begin
          // Wrong-path halt/load-use requests in ID are squashed by the flush.
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use_hit) begin
          pc_stop        = 1'b1;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
        end else if (halt_req) begin
          pc_stop        = 1'b1;
          if_id_write_en = 1'b0;
          id_ex_bubble   = 1'b1;
          state_d        = ST_HALT;
        end
      end

      ST_MULDIV: begin
        pc_stop        = 1'b1;
        if_id_write_en = 1'b0;
        id_ex_write_en = 1'b0;
        ex_mem_bubble  = 1'b1;
        muldiv_busy    = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HALT: begin
        // HALT sits in IF/ID while older instructions drain.
        pc_stop        = 1'b1;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
        halted         = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
